// File: rtl/screen_seq_if.sv
// Signal bundle between the screen sequencer, the debounced buttons, the game cores and the VGA mux.
interface screen_seq_if;
  logic       btn_start;
  logic       btn_sel;
  logic       game_win;
  logic       game_lose;
  logic [3:0] vga_control;
  logic       blink;
  logic       menu_sel;
  logic       game_en;
  logic       game_rst;

  modport master (
    output btn_start, btn_sel, game_win, game_lose,
    input  vga_control, blink, menu_sel, game_en, game_rst
  );

  modport slave (
    input  btn_start, btn_sel, game_win, game_lose,
    output vga_control, blink, menu_sel, game_en, game_rst
  );
endinterface

// File: rtl/screen_seq.sv
// Top-level screen sequencer: blank -> intro -> menu -> game -> result -> menu, driving the VGA mux select.
module screen_seq #(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned GAME_TIME   = 1_500_000_000,
  parameter int unsigned RESULT_HOLD = 250_000_000
) (
  input  logic        clk,
  input  logic        clr,
  screen_seq_if.slave bus
);

  localparam logic [3:0] S_BLANK  = 4'd0;
  localparam logic [3:0] S_INTRO  = 4'd1;
  localparam logic [3:0] S_MENU   = 4'd2;
  localparam logic [3:0] S_GAME_T = 4'd3;
  localparam logic [3:0] S_GAME_S = 4'd4;
  localparam logic [3:0] S_WIN    = 4'd5;
  localparam logic [3:0] S_LOSE   = 4'd6;

  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
  localparam logic [31:0] GAME_LAST  = 32'(GAME_TIME - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(RESULT_HOLD - 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_edge;
  logic       start_edge;
  logic       sel_edge;

  assign btn_raw    = {bus.btn_sel, bus.btn_start};
  assign start_edge = btn_edge[0];
  assign sel_edge   = btn_edge[1];

  // Two-flop synchronizer plus previous-value flop per button; one edge per press.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_q;
      logic sync2_q;
      logic prev_q;

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          prev_q  <= 1'b0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          prev_q  <= sync2_q;
        end
      end

      assign btn_edge[gi] = sync2_q & ~prev_q;
    end
  endgenerate

  logic [3:0]  state_q,     state_d;
  logic [31:0] timer_q,     timer_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q,     blink_d;
  logic        menu_sel_q,  menu_sel_d;
  logic        game_en_q,   game_en_d;
  logic        game_rst_q,  game_rst_d;

  logic in_game_q;
  logic in_game_d;
  logic in_result_q;

  assign in_game_q   = (state_q == S_GAME_T) || (state_q == S_GAME_S);
  assign in_game_d   = (state_d == S_GAME_T) || (state_d == S_GAME_S);
  assign in_result_q = (state_q == S_WIN) || (state_q == S_LOSE);

  always_comb begin
    state_d    = state_q;
    menu_sel_d = menu_sel_q;
    case (state_q)
      S_BLANK: state_d = S_INTRO;
      S_INTRO: begin
        if (start_edge) state_d = S_MENU;
      end
      S_MENU: begin
        // Start takes priority; a coincident select edge is dropped.
        if (start_edge) begin
          state_d = menu_sel_q ? S_GAME_S : S_GAME_T;
        end else if (sel_edge) begin
          menu_sel_d = ~menu_sel_q;
        end
      end
      S_GAME_T, S_GAME_S: begin
        if (bus.game_lose) begin
          state_d = S_LOSE;
        end else if (bus.game_win) begin
          state_d = S_WIN;
        end else if (timer_q == GAME_LAST) begin
          state_d = S_LOSE;
        end
      end
      S_WIN, S_LOSE: begin
        if (start_edge || (timer_q == HOLD_LAST)) state_d = S_MENU;
      end
      default: state_d = S_BLANK;
    endcase
  end

  // Shared game/result timer: restarts on every state change, idles elsewhere.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (in_game_q || in_result_q) begin
      timer_d = timer_q + 32'd1;
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_d == S_INTRO) && (state_q == S_INTRO)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_d     = blink_q;
      end
    end
  end

  always_comb begin
    game_en_d  = in_game_d;
    game_rst_d = in_game_d && !in_game_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_BLANK;
      timer_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      menu_sel_q  <= 1'b0;
      game_en_q   <= 1'b0;
      game_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      menu_sel_q  <= menu_sel_d;
      game_en_q   <= game_en_d;
      game_rst_q  <= game_rst_d;
    end
  end

  assign bus.vga_control = state_q;
  assign bus.blink       = blink_q;
  assign bus.menu_sel    = menu_sel_q;
  assign bus.game_en     = game_en_q;
  assign bus.game_rst    = game_rst_q;

endmodule

// File: tb/tb_screen_seq.sv
// Directed bench for screen_seq with a timeline-level reference model checked every cycle.
module tb_screen_seq;
  localparam int BLINK_DIV   = 4;
  localparam int GAME_TIME   = 20;
  localparam int RESULT_HOLD = 10;

  logic clk;
  logic clr;
  logic btn_start, btn_sel, game_win, game_lose;

  screen_seq_if bus ();

  assign bus.btn_start = btn_start;
  assign bus.btn_sel   = btn_sel;
  assign bus.game_win  = game_win;
  assign bus.game_lose = game_lose;

  screen_seq #(
    .BLINK_DIV  (BLINK_DIV),
    .GAME_TIME  (GAME_TIME),
    .RESULT_HOLD(RESULT_HOLD)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model: current screen, edge number at which it was entered, and scheduled button edges.
  int edge_n  = 0;
  int entered = 0;
  int scr     = 0;
  int msel    = 0;
  int last_st = 0;
  int last_se = 0;
  int q_st[$];
  int q_se[$];

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic model_reset();
    scr     = 0;
    msel    = 0;
    last_st = 0;
    last_se = 0;
    q_st.delete();
    q_se.delete();
    entered = edge_n;
  endtask

  task automatic model_step();
    int st_e;
    int se_e;
    int nxt;
    edge_n++;
    st_e = 0;
    se_e = 0;
    while (q_st.size() > 0 && q_st[0] <= edge_n) begin st_e = 1; void'(q_st.pop_front()); end
    while (q_se.size() > 0 && q_se[0] <= edge_n) begin se_e = 1; void'(q_se.pop_front()); end
    if (btn_start && last_st == 0) q_st.push_back(edge_n + 2);
    if (btn_sel && last_se == 0) q_se.push_back(edge_n + 2);
    last_st = int'(btn_start);
    last_se = int'(btn_sel);
    nxt = scr;
    case (scr)
      0: nxt = 1;
      1: if (st_e != 0) nxt = 2;
      2: begin
        if (st_e != 0) nxt = (msel != 0) ? 4 : 3;
        else if (se_e != 0) msel = 1 - msel;
      end
      3, 4: begin
        if (game_lose) nxt = 6;
        else if (game_win) nxt = 5;
        else if (edge_n - entered == GAME_TIME) nxt = 6;
      end
      5, 6: if (st_e != 0 || edge_n - entered == RESULT_HOLD) nxt = 2;
      default: nxt = 0;
    endcase
    if (nxt != scr) begin
      scr     = nxt;
      entered = edge_n;
    end
  endtask

  task automatic compare_all();
    int in_game;
    in_game = (scr == 3 || scr == 4) ? 1 : 0;
    check("vga_control", int'(bus.vga_control), scr);
    check("blink", int'(bus.blink), (scr == 1) ? ((edge_n - entered) / BLINK_DIV) % 2 : 0);
    check("menu_sel", int'(bus.menu_sel), msel);
    check("game_en", int'(bus.game_en), in_game);
    check("game_rst", int'(bus.game_rst), (in_game != 0 && edge_n == entered) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_vga(input int target, input int bound, output int n);
    n = 0;
    while (int'(bus.vga_control) != target && n < bound) begin
      tick();
      n++;
    end
    if (int'(bus.vga_control) != target) check("wait_timeout", int'(bus.vga_control), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int game_cyc;
    int rst_cnt;
    int hold_cyc;
    logic [15:0] blink_hist;

    clr = 1'b1;
    btn_start = 1'b0;
    btn_sel   = 1'b0;
    game_win  = 1'b0;
    game_lose = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_vga", int'(bus.vga_control), 0);
    check("rst_game_en", int'(bus.game_en), 0);

    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    compare_all();
    check("blank_first", int'(bus.vga_control), 0);

    blink_hist = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) check("intro_after_blank", int'(bus.vga_control), 1);
      blink_hist = {blink_hist[14:0], bus.blink};
    end
    check("blink_pattern", int'(blink_hist), 16'h0F0F);

    btn_start = 1'b1;
    wait_vga(2, 10, n);
    check("menu_latency", n, 3);
    check("menu_blink", int'(bus.blink), 0);
    repeat (50) tick();
    check("held_no_repeat", int'(bus.vga_control), 2);
    btn_start = 1'b0;
    repeat (3) tick();

    game_win = 1'b1;
    tick();
    game_win  = 1'b0;
    game_lose = 1'b1;
    tick();
    game_lose = 1'b0;
    repeat (2) tick();
    check("menu_ignores_game", int'(bus.vga_control), 2);

    btn_sel = 1'b1;
    repeat (2) tick();
    btn_sel = 1'b0;
    repeat (4) tick();
    check("menu_sel_toggled", int'(bus.menu_sel), 1);

    btn_start = 1'b1;
    wait_vga(4, 10, n);
    btn_start = 1'b0;
    game_cyc = 0;
    rst_cnt  = 0;
    for (int i = 0; i < 100 && int'(bus.vga_control) == 4; i++) begin
      game_cyc++;
      rst_cnt += int'(bus.game_rst);
      if (i == 5) btn_sel = 1'b1;
      if (i == 8) btn_sel = 1'b0;
      tick();
    end
    check("game_len", game_cyc, 20);
    check("game_rst_once", rst_cnt, 1);
    check("timeout_lose", int'(bus.vga_control), 6);
    check("game_en_drop", int'(bus.game_en), 0);

    hold_cyc = 0;
    for (int i = 0; i < 50 && int'(bus.vga_control) == 6; i++) begin
      hold_cyc++;
      tick();
    end
    check("lose_hold_len", hold_cyc, 10);
    check("hold_to_menu", int'(bus.vga_control), 2);
    check("menu_sel_retained", int'(bus.menu_sel), 1);

    btn_sel = 1'b1;
    repeat (2) tick();
    btn_sel = 1'b0;
    repeat (3) tick();
    check("menu_sel_back", int'(bus.menu_sel), 0);

    btn_sel   = 1'b1;
    btn_start = 1'b1;
    wait_vga(3, 10, n);
    check("simul_start_wins", int'(bus.menu_sel), 0);
    btn_sel   = 1'b0;
    btn_start = 1'b0;
    repeat (3) tick();

    game_win  = 1'b1;
    game_lose = 1'b1;
    tick();
    game_win  = 1'b0;
    game_lose = 1'b0;
    check("win_lose_same", int'(bus.vga_control), 6);

    repeat (3) tick();
    btn_start = 1'b1;
    wait_vga(2, 10, n);
    check("result_start_exit", n, 3);
    btn_start = 1'b0;
    repeat (3) tick();

    btn_sel = 1'b1;
    repeat (2) tick();
    btn_sel = 1'b0;
    repeat (3) tick();
    btn_start = 1'b1;
    wait_vga(4, 10, n);
    btn_start = 1'b0;
    repeat (4) tick();
    game_win = 1'b1;
    tick();
    game_win = 1'b0;
    check("win_entry", int'(bus.vga_control), 5);
    repeat (2) tick();
    check("pre_rst_menu_sel", int'(bus.menu_sel), 1);

    @(posedge clk);
    #2 clr = 1'b1;
    model_reset();
    #1;
    check("async_rst_vga", int'(bus.vga_control), 0);
    check("async_rst_blink", int'(bus.blink), 0);
    check("async_rst_menu_sel", int'(bus.menu_sel), 0);
    check("async_rst_game_en", int'(bus.game_en), 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    compare_all();
    check("post_rst_blank", int'(bus.vga_control), 0);
    tick();
    check("post_rst_intro", int'(bus.vga_control), 1);
    repeat (6) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/screen_seq.md
SCREEN_SEQ -- requirements
Module: screen_seq

Interface
REQ-001 Parameter BLINK_DIV, default 25_000_000, clock cycles per blink phase in intro screen.
REQ-002 Parameter GAME_TIME, default 1_500_000_000, clock cycles allowed per game before forced lose.
REQ-003 Parameter RESULT_HOLD, default 250_000_000, clock cycles win/lose screen is shown before auto-return to menu.
REQ-004 clk  in  1  system clock; the only clock; all state on rising edge.
REQ-005 clr  in  1  reset; asynchronous, active-high.
REQ-006 btn_start  in  1  start/confirm button; debounced, asynchronous to clk.
REQ-007 btn_sel  in  1  menu-select button; debounced, asynchronous to clk.
REQ-008 game_win  in  1  single-cycle win pulse from active game core, synchronous to clk.
REQ-009 game_lose  in  1  single-cycle lose pulse from active game core, synchronous to clk.
REQ-010 vga_control  out  4  screen select code for display mux: 0 blank, 1 intro, 2 menu, 3 game T, 4 game S, 5 win, 6 lose.
REQ-011 blink  out  1  intro blank phase; 1 = mux shows black.
REQ-012 menu_sel  out  1  highlighted menu item; 0 = game T, 1 = game S.
REQ-013 game_en  out  1  high while state is GAME_T or GAME_S.
REQ-014 game_rst  out  1  one-cycle pulse in first cycle of GAME_T or GAME_S.

Function
REQ-015 btn_start and btn_sel each pass a 2-flop synchronizer plus a registered previous value; edge = sync2 & ~prev; a button rising before clock edge k yields a state change at edge k+2.
REQ-016 All outputs registered; vga_control equals state encoding per REQ-010.
REQ-017 States: BLANK(0), INTRO(1), MENU(2), GAME_T(3), GAME_S(4), WIN(5), LOSE(6); encodings 7-15 unreachable; any illegal state recovers to BLANK next cycle.
REQ-018 BLANK -> INTRO unconditionally after one cycle.
REQ-019 INTRO: blink counter counts 0..BLINK_DIV-1, toggles blink at wrap; counter and blink are 0 on INTRO entry; start edge -> MENU.
REQ-020 blink 0 in every state except INTRO.
REQ-021 MENU: sel edge toggles menu_sel; start edge -> GAME_T if menu_sel=0, GAME_S if 1; menu_sel retains value across menu visits and clears only on reset.
REQ-022 Sel edge and start edge in same cycle in MENU: start wins, uses menu_sel before toggle, toggle discarded.
REQ-023 GAME_T/GAME_S: game timer clears on entry, increments each cycle; game_lose pulse -> LOSE; else game_win pulse -> WIN; timer reaching GAME_TIME-1 with no pulse -> LOSE.
REQ-024 game_win and game_lose in same cycle -> LOSE.
REQ-025 game_win/game_lose ignored outside GAME_T/GAME_S; buttons ignored in GAME_T/GAME_S.
REQ-026 WIN/LOSE: hold timer clears on entry; start edge or hold timer reaching RESULT_HOLD-1 -> MENU; simultaneous case -> MENU once.
REQ-027 Timers 32 bits; no wrap beyond terminal value since state leaves at terminal count.
REQ-028 Button held continuously produces exactly one edge; no auto-repeat.

Reset
REQ-029 clr high asynchronously forces state BLANK, vga_control=0, blink=0, menu_sel=0, game_en=0, game_rst=0, all counters and synchronizer/prev flops 0.
REQ-030 clr asserted mid-game or mid-result returns to BLANK immediately; after release, sequence resumes at REQ-018 with no stale edge.

Verification (BLINK_DIV=4, GAME_TIME=20, RESULT_HOLD=10)
REQ-031 Release clr -> vga_control 0 for 1 cycle, then 1; blink toggles every 4 cycles (0000111100001111).
REQ-032 In INTRO raise btn_start -> vga_control=2 at edge k+2; blink=0; hold button 50 cycles -> no further transition.
REQ-033 In MENU pulse btn_sel once, then btn_start -> menu_sel=1, vga_control=4, game_en=1, game_rst high exactly 1 cycle.
REQ-034 In GAME_T assert game_win and game_lose same cycle -> vga_control=6 next cycle; after 10 cycles with no button -> vga_control=2.
REQ-035 In GAME_S no pulses -> vga_control=6 after exactly 20 cycles in game; game_en drops same cycle.
REQ-036 Assert clr during WIN (vga_control=5) -> outputs 0 asynchronously; menu_sel=0 after release; vga_control 0 then 1.
